// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: evaluates a programmable N_IN-input boolean function stored as a
// 2^N_IN-bit truth table. It has two modes:
//   - single eval: one request in, one result beat out, one cycle later.
//   - sweep: walks every input vector in ascending order, captures the results and
//     compares the captured table against the programmed one.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// A producer holds valid and its payload stable until the transfer. Ready may
// depend combinationally on valid, but valid never depends on ready.
module lut_sweep_eval #(
    parameter  int N_IN  = 4,
    localparam int TBL_W = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [TBL_W-1:0]  cfg_table,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   out_vec,
    output logic              out_f,
    output logic              busy,
    output logic              done,
    output logic [TBL_W-1:0]  sweep_tbl,
    output logic              sweep_ok,
    output logic              dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TBL_W - 1);

    state_e             state_q, state_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [N_IN-1:0]    out_vec_q, out_vec_d;
    logic               out_f_q, out_f_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   sweep_tbl_q, sweep_tbl_d;
    logic               sweep_ok_q, sweep_ok_d;

    logic               load_en;
    logic               out_fire;
    logic               in_fire;
    logic               last_beat;
    logic [TBL_W-1:0]   sweep_acc;

    // Output stage may load when empty or when its current beat leaves this cycle.
    assign load_en   = ~out_valid_q | out_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign last_beat = (out_vec_q == LAST_VEC);
    assign in_ready  = rst_n & (state_q == ST_IDLE) & ~start & load_en;
    assign in_fire   = in_valid & in_ready;

    // Next-state logic: mode control, config, output stage and sweep capture.
    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_f_d     = out_f_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sweep_tbl_d = sweep_tbl_q;
        sweep_ok_d  = sweep_ok_q;
        sweep_acc   = sweep_tbl_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    tbl_d = cfg_table;
                end
                // A sweep may only begin once the output stage is empty, so no
                // single-eval beat gets mixed into the sweep stream.
                if (start && !out_valid_q) begin
                    state_d     = ST_SWEEP;
                    idx_d       = '0;
                    sweep_tbl_d = '0;
                    sweep_ok_d  = 1'b0;
                    busy_d      = 1'b1;
                end
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_vec_d   = in_vec;
                    out_f_d     = tbl_q[in_vec];
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (out_fire) begin
                    sweep_acc[out_vec_q] = out_f_q;
                end
                sweep_tbl_d = sweep_acc;
                // Once the last vector is presented nothing else is loaded; its
                // acceptance ends the sweep. Any other free slot takes the next idx.
                if (out_fire && last_beat) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    sweep_ok_d  = (sweep_acc == tbl_q);
                end else if (load_en) begin
                    out_valid_d = 1'b1;
                    out_vec_d   = idx_q;
                    out_f_d     = tbl_q[idx_q];
                    idx_d       = idx_q + N_IN'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tbl_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_f_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sweep_tbl_q <= '0;
            sweep_ok_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_f_q     <= out_f_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sweep_tbl_q <= sweep_tbl_d;
            sweep_ok_q  <= sweep_ok_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_f     = out_f_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sweep_tbl = sweep_tbl_q;
    assign sweep_ok  = sweep_ok_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Testbench for lut_sweep_eval (N_IN = 4): scenario tasks drive stimulus and push
// expected beats; a negedge monitor pops and compares each transferred beat.
module tb_lut_sweep_eval;

  localparam int N_IN  = 4;
  localparam int TBL_W = 16;
  localparam int EXP_W = N_IN + 1;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [TBL_W-1:0]  cfg_table;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [N_IN-1:0]   out_vec;
  logic              out_f;
  logic              busy;
  logic              done;
  logic [TBL_W-1:0]  sweep_tbl;
  logic              sweep_ok;
  logic              dbg_state;

  logic [EXP_W-1:0]  exp_q[$];
  logic [TBL_W-1:0]  m_tbl;
  int                errors;
  int                checks;

  lut_sweep_eval #(.N_IN(N_IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_table (cfg_table),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_f     (out_f),
    .busy      (busy),
    .done      (done),
    .sweep_tbl (sweep_tbl),
    .sweep_ok  (sweep_ok),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: a beat transfers at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got vec=%0d f=%0d, expected no beat", out_vec, out_f);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_vec, out_f} !== e) begin
          errors++;
          $display("FAIL beat: got vec=%0d f=%0d, expected vec=%0d f=%0d",
                   out_vec, out_f, e[EXP_W-1:1], e[0]);
        end
      end
    end
  end

  // driver: present one single-eval request, push expected on acceptance
  task automatic drive_eval(input logic [N_IN-1:0] v);
    int tries;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = v;
    tries    = 0;
    @(negedge clk);
    while (!in_ready && tries < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      tries++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL eval_accept: in_ready=%0d for vec=%0d, expected 1", in_ready, v);
    end else begin
      exp_q.push_back({v, m_tbl[v]});
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_vec, out_f, busy, done, sweep_tbl, sweep_ok, in_ready, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ov=%0d vec=%0d f=%0d busy=%0d done=%0d stbl=%h ok=%0d ir=%0d st=%0d, expected all 0",
               out_valid, out_vec, out_f, busy, done, sweep_tbl, sweep_ok, in_ready, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%0d, expected 1", in_ready);
    end
  endtask

  task automatic load_table(input logic [TBL_W-1:0] t);
    @(posedge clk); #1;
    cfg_we    = 1'b1;
    cfg_table = t;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
    m_tbl     = t;
  endtask

  task automatic test_single_eval();
    out_ready = 1'b1;
    load_table(16'hA5C3);
    drive_eval(4'd0);
    drive_eval(4'd2);
    drive_eval(4'd15);
    go_idle();
    // one cycle after the last accept the result for vec 15 is presented
    checks++;
    if ({out_valid, out_vec, out_f} !== {1'b1, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL eval_latency: ov=%0d vec=%0d f=%0d, expected ov=1 vec=15 f=1",
               out_valid, out_vec, out_f);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL eval_drain: out_valid=%0d, expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive_eval(4'd5);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 4'd5 || out_f !== m_tbl[5]) begin
        errors++;
        $display("FAIL bp_hold: ir=%0d ov=%0d vec=%0d f=%0d, expected ir=0 ov=1 vec=5 f=%0d",
                 in_ready, out_valid, out_vec, out_f, m_tbl[5]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0d, expected 1", in_ready);
    end else begin
      exp_q.push_back({4'd9, m_tbl[9]});
    end
    go_idle();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%0d pending=%0d, expected 0 and 0", out_valid, exp_q.size());
    end
  endtask

  task automatic run_sweep(input logic [TBL_W-1:0] t, input bit toggle, input bit cfg_mid, input string nm);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    cfg_we    = 1'b1;
    cfg_table = t;
    start     = 1'b1;
    m_tbl     = t;
    for (int i = 0; i < TBL_W; i++) exp_q.push_back({4'(i), t[i]});
    @(posedge clk); #1;
    cfg_we = 1'b0;
    start  = 1'b0;
    cyc    = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: busy=%0d state=%0d, expected 1 and 1", nm, busy, dbg_state);
    end
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle) out_ready = ~out_ready;
      if (cfg_mid) begin
        cfg_we    = (cyc == 6);
        cfg_table = ~t;
      end
      @(negedge clk);
    end
    cfg_we    = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0d after %0d cycles, expected 1", nm, done, cyc);
    end
    if (!toggle) begin
      checks++;
      if (cyc != 17) begin
        errors++;
        $display("FAIL %s_latency: done after %0d cycles, expected 17", nm, cyc);
      end
    end
    checks++;
    if (exp_q.size() != 0 || sweep_tbl !== t || sweep_ok !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: pending=%0d stbl=%h ok=%0d busy=%0d, expected 0 %h 1 0",
               nm, exp_q.size(), sweep_tbl, sweep_ok, busy, t);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || sweep_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_after: done=%0d ov=%0d ok=%0d, expected 0 0 1", nm, done, out_valid, sweep_ok);
    end
  endtask

  task automatic test_sweep();
    run_sweep(16'hA5C3, 1'b0, 1'b0, "sweep");
  endtask

  task automatic test_sweep_backpressure();
    run_sweep(16'hA5C3, 1'b1, 1'b1, "sweep_bp");
    // table must still be A5C3: vec 0 is 1 there but 0 in the rejected table
    drive_eval(4'd0);
    drive_eval(4'd6);
    go_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < TBL_W; i++) exp_q.push_back({4'(i), m_tbl[i]});
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (!(out_valid && out_vec == 4'd7) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!(out_valid && out_vec == 4'd7)) begin
      errors++;
      $display("FAIL rst_sweep_reach7: ov=%0d vec=%0d, expected ov=1 vec=7", out_valid, out_vec);
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sweep_tbl !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_sweep_state: st=%0d ov=%0d busy=%0d done=%0d stbl=%h ir=%0d, expected all 0",
               dbg_state, out_valid, busy, done, sweep_tbl, in_ready);
    end
    rst_n = 1'b1;
    m_tbl = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_sweep_nodone: done=%0d busy=%0d, expected 0 0", done, busy);
      end
    end
    // table cleared: every vector evaluates to 0
    drive_eval(4'd0);
    drive_eval(4'd15);
    drive_eval(4'($urandom_range(1, 14)));
    go_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_table = '0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    m_tbl     = '0;

    test_reset();
    test_single_eval();
    test_backpressure();
    test_sweep();
    test_sweep_backpressure();
    test_reset_mid_sweep();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d beats pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
